// File: rtl/spi_slave.sv
// SPI responder: sck/ss/mosi are oversampled into clk_in, frames are shifted
// against a one-word transmit buffer, and completed words land in a holding register.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  spe_in,
  input  logic                  cpol_in,
  input  logic                  cpha_in,
  input  logic                  lsbfe_in,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  tx_valid_in,
  output logic                  tx_ready_out,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  rx_valid_out,
  input  logic                  rx_ack_in,
  input  logic                  ovr_clr_in,
  output logic                  overrun_out,
  output logic                  busy_out,
  input  logic                  sck_in,
  input  logic                  ss_in,
  input  logic                  mosi_in,
  output logic                  miso_out,
  output logic                  miso_oe_out
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ACTIVE = 2'd2} state_t;
  state_t state;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                   sck_q, ss_q;
  logic                   sck_s, ss_s, mosi_s;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   ss_fall, word_done, tx_accept;
  logic [DATA_WIDTH-1:0]  tx_buf, tx_sr, rx_sr;
  logic [DATA_WIDTH-1:0]  rx_next, tx_shifted, reload_word;
  logic [CW-1:0]          bit_cnt;
  logic                   first_bit, reload_pend;

  // Synchronisers idle at the bus idle levels so reset never looks like an edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sck_sync  <= {SYNC_STAGES{cpol_in}};
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_q     <= cpol_in;
      ss_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      sck_q     <= sck_sync[SYNC_STAGES-1];
      ss_q      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign lead_edge   = (sck_s ^ sck_q) & (sck_s ^ cpol_in);
  assign trail_edge  = (sck_s ^ sck_q) & ~(sck_s ^ cpol_in);
  assign sample_edge = cpha_in ? trail_edge : lead_edge;
  assign shift_edge  = cpha_in ? lead_edge : trail_edge;
  assign ss_fall     = ss_q & ~ss_s;

  assign rx_next     = lsbfe_in ? {mosi_s, rx_sr[DATA_WIDTH-1:1]} : {rx_sr[DATA_WIDTH-2:0], mosi_s};
  assign tx_shifted  = lsbfe_in ? {1'b0, tx_sr[DATA_WIDTH-1:1]} : {tx_sr[DATA_WIDTH-2:0], 1'b0};
  assign reload_word = tx_ready_out ? '0 : tx_buf;
  assign word_done   = sample_edge && (bit_cnt == CW'(DATA_WIDTH - 1));
  assign miso_out    = lsbfe_in ? tx_sr[0] : tx_sr[DATA_WIDTH-1];

  // Transmit handshake: a word is taken on a clk_in edge where tx_valid_in and
  // tx_ready_out are both 1 (and spe_in=1); ready stays low until the word is loaded.
  assign tx_accept = tx_valid_in & tx_ready_out & spe_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      tx_buf       <= '0;
      tx_ready_out <= 1'b1;
      tx_sr        <= '0;
      rx_sr        <= '0;
      rx_data_out  <= '0;
      rx_valid_out <= 1'b0;
      overrun_out  <= 1'b0;
      busy_out     <= 1'b0;
      miso_oe_out  <= 1'b0;
      bit_cnt      <= '0;
      first_bit    <= 1'b0;
      reload_pend  <= 1'b0;
    end else begin
      if (rx_ack_in && rx_valid_out) rx_valid_out <= 1'b0;
      if (ovr_clr_in) overrun_out <= 1'b0;
      if (tx_accept) begin
        tx_buf       <= tx_data_in;
        tx_ready_out <= 1'b0;
      end
      if (!spe_in) begin
        state        <= IDLE;
        busy_out     <= 1'b0;
        miso_oe_out  <= 1'b0;
        tx_ready_out <= 1'b1;
        rx_valid_out <= 1'b0;
        overrun_out  <= 1'b0;
        reload_pend  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            busy_out    <= 1'b0;
            miso_oe_out <= 1'b0;
            if (ss_fall) begin
              state    <= LOAD;
              busy_out <= 1'b1;
            end
          end
          LOAD: begin
            tx_sr <= reload_word;
            if (!tx_ready_out) tx_ready_out <= 1'b1;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            first_bit   <= 1'b1;
            reload_pend <= 1'b0;
            miso_oe_out <= 1'b1;
            state       <= ACTIVE;
          end
          ACTIVE: begin
            if (ss_s) begin
              // Partial words are dropped; an unloaded buffer word survives.
              state       <= IDLE;
              busy_out    <= 1'b0;
              miso_oe_out <= 1'b0;
              reload_pend <= 1'b0;
            end else begin
              if (sample_edge) begin
                rx_sr <= rx_next;
                if (word_done) begin
                  bit_cnt <= '0;
                  if (!rx_valid_out || rx_ack_in) begin
                    rx_data_out  <= rx_next;
                    rx_valid_out <= 1'b1;
                  end else if (!ovr_clr_in) begin
                    overrun_out <= 1'b1;
                  end
                  if (cpha_in) begin
                    tx_sr <= reload_word;
                    if (!tx_ready_out) tx_ready_out <= 1'b1;
                    first_bit <= 1'b1;
                  end else begin
                    reload_pend <= 1'b1;
                  end
                end else begin
                  bit_cnt <= bit_cnt + CW'(1);
                end
              end
              if (shift_edge) begin
                if (reload_pend) begin
                  tx_sr <= reload_word;
                  if (!tx_ready_out) tx_ready_out <= 1'b1;
                  reload_pend <= 1'b0;
                end else if (cpha_in && first_bit) begin
                  first_bit <= 1'b0;
                end else begin
                  tx_sr <= tx_shifted;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged SPI master drives frames and a word-level
// model of the buffer, holding register and overrun flag predicts every result.
module tb_spi_slave;
  localparam int W = 8;
  localparam int S = 2;
  localparam int H = 5;

  logic         clk_in = 1'b0;
  logic         rst_in, spe_in, cpol_in, cpha_in, lsbfe_in;
  logic [W-1:0] tx_data_in;
  logic         tx_valid_in, tx_ready_out;
  logic [W-1:0] rx_data_out;
  logic         rx_valid_out, rx_ack_in, ovr_clr_in, overrun_out, busy_out;
  logic         sck_in, ss_in, mosi_in, miso_out, miso_oe_out;

  spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .spe_in(spe_in), .cpol_in(cpol_in),
    .cpha_in(cpha_in), .lsbfe_in(lsbfe_in), .tx_data_in(tx_data_in),
    .tx_valid_in(tx_valid_in), .tx_ready_out(tx_ready_out),
    .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out), .rx_ack_in(rx_ack_in),
    .ovr_clr_in(ovr_clr_in), .overrun_out(overrun_out), .busy_out(busy_out),
    .sck_in(sck_in), .ss_in(ss_in), .mosi_in(mosi_in), .miso_out(miso_out),
    .miso_oe_out(miso_oe_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard and model state
  int           checks = 0;
  int           errors = 0;
  int           lat;
  logic [W-1:0] exp_q[$];
  bit           m_valid, m_ovr, m_buf_full;
  logic [W-1:0] m_data, m_buf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_ovr = 0; m_data = '0; m_buf_full = 0; m_buf = '0;
    exp_q.delete();
  endtask

  // A load (frame start or back-to-back reload) takes the buffer or zero.
  task automatic model_load();
    exp_q.push_back(m_buf_full ? m_buf : '0);
    m_buf_full = 0;
  endtask

  task automatic model_rx(input logic [W-1:0] word);
    if (m_valid) begin
      if (!ovr_clr_in) m_ovr = 1;
    end else begin
      m_data  = word;
      m_valid = 1;
    end
  endtask

  // driver tasks
  task automatic wait_h(input bit meas);
    for (int k = 1; k <= H; k++) begin
      @(negedge clk_in);
      if (meas && lat == 99 && rx_valid_out) lat = k;
    end
  endtask

  task automatic set_mode(input bit pol, input bit pha, input bit lsb);
    @(negedge clk_in);
    cpol_in = pol; cpha_in = pha; lsbfe_in = lsb; sck_in = pol;
    repeat (8) @(negedge clk_in);
  endtask

  task automatic tx_write(input logic [W-1:0] d);
    int n = 0;
    @(negedge clk_in);
    tx_data_in = d; tx_valid_in = 1;
    while (!tx_ready_out && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 200) check("tx_write_timeout", n, 0);
    @(negedge clk_in);
    tx_valid_in = 0;
    m_buf = d; m_buf_full = 1;
  endtask

  task automatic rx_ack();
    @(negedge clk_in); rx_ack_in = 1;
    @(negedge clk_in); rx_ack_in = 0;
    m_valid = 0;
  endtask

  task automatic ovr_clear();
    @(negedge clk_in); ovr_clr_in = 1;
    @(negedge clk_in); ovr_clr_in = 0;
    m_ovr = 0;
  endtask

  task automatic ss_low();
    @(negedge clk_in); ss_in = 0;
    repeat (6) @(negedge clk_in);
    model_load();
  endtask

  task automatic ss_high();
    wait_h(0);
    ss_in = 1;
    repeat (4) @(negedge clk_in);
    sck_in = cpol_in;
    repeat (6) @(negedge clk_in);
    exp_q.delete();
  endtask

  task automatic master_bits(input int nedges, input logic [W-1:0] mo, output logic [W-1:0] mi);
    int i, b, samp_e;
    mi = '0;
    samp_e = cpha_in ? 2*W-1 : 2*W-2;
    if (!cpha_in) mosi_in = mo[lsbfe_in ? 0 : W-1];
    wait_h(0);
    for (int e = 0; e < nedges; e++) begin
      i = e / 2;
      b = lsbfe_in ? i : W-1-i;
      if (e % 2 == 0) begin
        sck_in = ~cpol_in;
        if (!cpha_in) mi[b] = miso_out;
        else mosi_in = mo[b];
      end else begin
        sck_in = cpol_in;
        if (cpha_in) mi[b] = miso_out;
        else if (i + 1 < W) mosi_in = mo[lsbfe_in ? i+1 : W-2-i];
      end
      if (e == samp_e) lat = 99;
      wait_h(e == samp_e);
    end
  endtask

  task automatic master_word(input logic [W-1:0] mo, output logic [W-1:0] mi);
    logic [W-1:0] exp;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    master_bits(2*W, mo, mi);
    check("miso_word", mi, exp);
    model_rx(mo);
    model_load();
    check("rx_valid", rx_valid_out, m_valid);
    check("rx_data", rx_data_out, m_data);
    check("overrun", overrun_out, m_ovr);
  endtask

  task automatic partial(input int nedges);
    logic [W-1:0] mi;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    master_bits(nedges, W'($urandom), mi);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_ready"}, tx_ready_out, 1);
    check({tag, "_rx_valid"}, rx_valid_out, 0);
    check({tag, "_rx_data"}, rx_data_out, 0);
    check({tag, "_overrun"}, overrun_out, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_miso"}, miso_out, 0);
    check({tag, "_miso_oe"}, miso_oe_out, 0);
  endtask

  initial begin
    logic [W-1:0] mi, r1, r2, r3, xw, yw;
    rst_in = 1; spe_in = 1; cpol_in = 0; cpha_in = 0; lsbfe_in = 0;
    tx_data_in = '0; tx_valid_in = 0; rx_ack_in = 0; ovr_clr_in = 0;
    sck_in = 0; ss_in = 1; mosi_in = 0;
    model_reset();
    repeat (3) @(negedge clk_in);
    check_reset_outputs("reset");
    rst_in = 0;
    repeat (3) @(negedge clk_in);

    // mode 0, MSB first: 0xA5 out, 0x3C in
    tx_write(8'hA5);
    check("t1_tx_ready_full", tx_ready_out, 0);
    ss_low();
    check("t1_tx_ready_after_load", tx_ready_out, 1);
    check("t1_busy", busy_out, 1);
    check("t1_miso_oe", miso_oe_out, 1);
    master_word(8'h3C, mi);
    check("t1_master_read", mi, 8'hA5);
    check("t1_rx_data", rx_data_out, 8'h3C);
    check("t1_rx_valid_latency_ok", (lat <= S + 2), 1);
    ss_high();
    check("t1_busy_after", busy_out, 0);
    rx_ack();
    check("t1_rx_valid_acked", rx_valid_out, 0);

    // all four modes, LSB first
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0], 1'b1);
      tx_write(8'h81);
      ss_low();
      master_word(8'h01, mi);
      check("t2_master_read", mi, 8'h81);
      check("t2_rx_data", rx_data_out, 8'h01);
      ss_high();
      rx_ack();
    end

    // back-to-back words, second buffer written mid-frame
    for (int m = 0; m < 2; m++) begin
      set_mode(m[0], m[0], m[0]);
      r1 = W'($urandom); r2 = W'($urandom);
      tx_write(W'($urandom));
      ss_low();
      tx_write(8'h5A);
      master_word(r1, mi);
      rx_ack();
      master_word(r2, mi);
      check("t3_second_word", mi, 8'h5A);
      check("t3_rx_data2", rx_data_out, r2);
      rx_ack();
      check("t3_overrun", overrun_out, 0);
      ss_high();
    end

    // no tx write, overrun, clear; then clear held across an overrun
    set_mode(0, 0, 0);
    r1 = W'($urandom); r2 = W'($urandom);
    ss_low();
    master_word(r1, mi);
    check("t4_zero_word", mi, 8'h00);
    master_word(r2, mi);
    check("t4_overrun_set", overrun_out, 1);
    check("t4_rx_data_kept", rx_data_out, r1);
    ss_high();
    ovr_clear();
    check("t4_overrun_cleared", overrun_out, 0);
    @(negedge clk_in); ovr_clr_in = 1;
    ss_low();
    master_word(W'($urandom), mi);
    check("t4_clr_precedence", overrun_out, 0);
    ss_high();
    ovr_clr_in = 0;
    rx_ack();
    check("t4_ack_idle_ignored_pre", rx_valid_out, 0);
    rx_ack();
    check("t4_ack_idle_ignored", rx_valid_out, 0);

    // aborted frame after 5 edges, with an unread word held
    r1 = W'($urandom); xw = W'($urandom); yw = W'($urandom);
    ss_low();
    master_word(r1, mi);
    ss_high();
    tx_write(xw);
    ss_low();
    tx_write(yw);
    partial(5);
    ss_high();
    check("t5_busy", busy_out, 0);
    check("t5_rx_valid_kept", rx_valid_out, 1);
    check("t5_rx_data_kept", rx_data_out, r1);
    check("t5_overrun", overrun_out, 0);
    rx_ack();
    r2 = W'($urandom);
    ss_low();
    master_word(r2, mi);
    check("t5_buffer_kept", mi, yw);
    check("t5_next_rx", rx_data_out, r2);
    ss_high();
    rx_ack();

    // spe_in=0 mid-frame
    ss_low();
    master_word(W'($urandom), mi);
    ss_high();
    tx_write(W'($urandom));
    ss_low();
    tx_write(W'($urandom));
    partial(6);
    @(negedge clk_in); spe_in = 0;
    repeat (2) @(negedge clk_in);
    m_valid = 0; m_ovr = 0; m_buf_full = 0;
    check("t6_miso_oe", miso_oe_out, 0);
    check("t6_tx_ready", tx_ready_out, 1);
    check("t6_busy", busy_out, 0);
    check("t6_rx_valid", rx_valid_out, 0);
    tx_data_in = 8'hFF; tx_valid_in = 1;
    repeat (3) @(negedge clk_in);
    tx_valid_in = 0;
    check("t6_write_blocked", tx_ready_out, 1);
    ss_high();
    spe_in = 1;
    repeat (3) @(negedge clk_in);
    ss_low();
    master_word(W'($urandom), mi);
    check("t6_flushed_word", mi, 8'h00);
    ss_high();
    rx_ack();

    // reset mid-frame
    tx_write(W'($urandom));
    ss_low();
    partial(7);
    rst_in = 1;
    #1;
    check_reset_outputs("t7");
    @(negedge clk_in);
    ss_in = 1; sck_in = cpol_in;
    repeat (2) @(negedge clk_in);
    rst_in = 0;
    model_reset();
    repeat (4) @(negedge clk_in);

    // randomized frames
    for (int f = 0; f < 16; f++) begin
      int  nw;
      bit  ack_each;
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      nw = $urandom_range(1, 3);
      ack_each = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) tx_write(W'($urandom));
      ss_low();
      for (int k = 0; k < nw; k++) begin
        if (k + 1 < nw && $urandom_range(0, 1) == 1) tx_write(W'($urandom));
        master_word(W'($urandom), mi);
        if (ack_each) rx_ack();
      end
      ss_high();
      check("rand_busy_idle", busy_out, 0);
      rx_ack();
      ovr_clear();
      check("rand_cleanup_valid", rx_valid_out, m_valid);
      check("rand_cleanup_ovr", overrun_out, m_ovr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
